// File: rtl/rv_mem_pkg.sv
// -----------------------------------------------------------------------------
// rv_mem_pkg
// Shared definitions for the data-memory subsystem:
//   - MMIO register offsets within the 16-byte MMIO window
//   - STATUS register bit positions
//   - register-select enum produced by the address decoder
//   - mmio_decode(): maps an access to its register select
// -----------------------------------------------------------------------------
package rv_mem_pkg;

    // Byte offsets of the MMIO registers relative to the MMIO base
    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CYCLE_OFS  = 4'h8;
    localparam logic [3:0] RSVD_OFS   = 4'hC;

    // STATUS register bit positions
    localparam int unsigned ST_FULL_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

    // Target selected by the current data-port address
    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_TXDATA = 3'd1,
        SEL_STATUS = 3'd2,
        SEL_CYCLE  = 3'd3,
        SEL_RSVD   = 3'd4
    } mmio_sel_e;

    // Word offset inside the MMIO window -> register select; RAM when not a hit
    function automatic mmio_sel_e mmio_decode(input logic hit, input logic [1:0] word_ofs);
        mmio_sel_e sel;
        if (!hit) begin
            sel = SEL_RAM;
        end else begin
            case ({word_ofs, 2'b00})
                TXDATA_OFS: sel = SEL_TXDATA;
                STATUS_OFS: sel = SEL_STATUS;
                CYCLE_OFS:  sel = SEL_CYCLE;
                RSVD_OFS:   sel = SEL_RSVD;
                default:    sel = SEL_RSVD;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv_fifo.sv
// -----------------------------------------------------------------------------
// rv_fifo
// Synchronous FIFO with first-word-fall-through output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head entry, forced to zero while empty
//   full/empty : occupancy flags
//   count      : occupancy, $clog2(DEPTH)+1 bits
// Overflow reporting is left to the instantiating block.
// -----------------------------------------------------------------------------
module rv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty = (count_r == {CW{1'b0}});
    assign full  = (count_r == CW'(DEPTH));
    assign count = count_r;

    // A pop needs data; a push into a full FIFO needs a simultaneous pop to free the slot
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Head is masked while empty so stale storage never reaches the output
    assign dout = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rv_dmem.sv
// -----------------------------------------------------------------------------
// rv_dmem
// Data-memory subsystem on the core's data port.
//   Low addresses : word RAM (aliases above DMEM_WORDS words, not reset)
//   MMIO_BASE page: TXDATA (push byte), STATUS (full/empty/overflow/count,
//                   overflow is write-1-to-clear), CYCLE (free-running
//                   counter, any write clears), reserved word.
// Ports:
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-low reset
//   dmem_addr    : byte address, bits [1:0] ignored
//   dmem_dataout : write data from the core
//   memrw        : 1 = write at this edge, 0 = read
//   dmem_datain  : combinational read data to the core
//   tx_data      : TX FIFO head byte (0 when empty)
//   tx_valid     : TX FIFO non-empty
//   tx_ready     : consumer takes the head byte at the next edge
// -----------------------------------------------------------------------------
module rv_dmem #(
    parameter int unsigned          DPWIDTH    = 32,
    parameter int unsigned          DMEM_WORDS = 1024,
    parameter int unsigned          FIFO_DEPTH = 8,
    parameter logic [DPWIDTH-1:0]   MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] dmem_addr,
    input  logic [DPWIDTH-1:0] dmem_dataout,
    input  logic               memrw,
    output logic [DPWIDTH-1:0] dmem_datain,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    import rv_mem_pkg::*;

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [DPWIDTH-1:0] ram_r [DMEM_WORDS];
    logic [DPWIDTH-1:0] cycle_r;
    logic               ovf_r;

    logic               mmio_hit_s;
    mmio_sel_e          sel_s;
    logic [AW-1:0]      ram_idx_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [CW-1:0]      count_s;
    logic [7:0]         head_s;
    logic               ovf_set_s;
    logic               ovf_clr_s;
    logic               cyc_clr_s;
    logic [DPWIDTH-1:0] status_s;
    logic [DPWIDTH-1:0] rdata_s;
    logic               addr_unused_s;

    // Byte-lane bits never select anything on a word-wide port
    assign addr_unused_s = &{1'b0, dmem_addr[1:0]};

    // Address decode: MMIO page match on the upper bits, RAM index from the low word bits
    assign mmio_hit_s = (dmem_addr[DPWIDTH-1:4] == MMIO_BASE[DPWIDTH-1:4]);
    assign sel_s      = mmio_decode(mmio_hit_s, dmem_addr[3:2]);
    assign ram_idx_s  = dmem_addr[AW+1:2];

    // Write strobes for each MMIO side effect
    assign push_s    = memrw && (sel_s == SEL_TXDATA);
    assign ovf_clr_s = memrw && (sel_s == SEL_STATUS) && dmem_dataout[ST_OVF_BIT];
    assign cyc_clr_s = memrw && (sel_s == SEL_CYCLE);

    // Consumer handshake; an empty FIFO makes tx_ready irrelevant
    assign pop_s     = !empty_s && tx_ready;
    // A push is only dropped when full and no slot frees up this cycle
    assign ovf_set_s = push_s && full_s && !pop_s;

    rv_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (dmem_dataout[7:0]),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign tx_valid = !empty_s;
    assign tx_data  = head_s;

    // STATUS word assembly; unlisted bits stay zero
    always_comb begin
        status_s                            = {DPWIDTH{1'b0}};
        status_s[ST_FULL_BIT]               = full_s;
        status_s[ST_EMPTY_BIT]              = empty_s;
        status_s[ST_OVF_BIT]                = ovf_r;
        status_s[ST_COUNT_LSB +: CW]        = count_s;
    end

    // Read-data mux; reads are combinational and independent of memrw
    always_comb begin
        rdata_s = {DPWIDTH{1'b0}};
        case (sel_s)
            SEL_RAM:    rdata_s = ram_r[ram_idx_s];
            SEL_TXDATA: rdata_s = {DPWIDTH{1'b0}};
            SEL_STATUS: rdata_s = status_s;
            SEL_CYCLE:  rdata_s = cycle_r;
            SEL_RSVD:   rdata_s = {DPWIDTH{1'b0}};
            default:    rdata_s = {DPWIDTH{1'b0}};
        endcase
    end

    assign dmem_datain = rdata_s;

    // Word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (memrw && (sel_s == SEL_RAM)) begin
            ram_r[ram_idx_s] <= dmem_dataout;
        end
    end

    // Sticky overflow flag; set and clear come from different registers so never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Free-running cycle counter; a write clears it and wins over the increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_r <= {DPWIDTH{1'b0}};
        end else if (cyc_clr_s) begin
            cycle_r <= {DPWIDTH{1'b0}};
        end else begin
            cycle_r <= cycle_r + {{(DPWIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_rv_dmem.sv
// -----------------------------------------------------------------------------
// tb_rv_dmem
// Directed bench for rv_dmem: RAM aliasing, TX FIFO fill/drain/overflow,
// full-with-pop push, backpressure, cycle counter clear/wrap, async reset.
// Inputs change just after the falling edge; outputs are sampled in the low
// phase, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_rv_dmem;

    localparam logic [31:0] MB      = 32'hFFFF_0000;
    localparam logic [31:0] A_TX    = MB + 32'h0;
    localparam logic [31:0] A_ST    = MB + 32'h4;
    localparam logic [31:0] A_CYC   = MB + 32'h8;
    localparam logic [31:0] A_RSVD  = MB + 32'hC;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_dataout;
    logic        memrw;
    logic [31:0] dmem_datain;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    rv_dmem dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_addr    (dmem_addr),
        .dmem_dataout (dmem_dataout),
        .memrw        (memrw),
        .dmem_datain  (dmem_datain),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    // Free-running clock, first rising edge at t=10
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts a failure and reports it
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write cycle: drive, let one rising edge commit it, return at the falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dmem_addr    = a;
        dmem_dataout = d;
        memrw        = 1'b1;
        @(negedge clk);
        memrw        = 1'b0;
    endtask

    // Combinational read check within the current low phase
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memrw     = 1'b0;
        dmem_addr = a;
        #1;
        chk(tag, dmem_datain, exp);
    endtask

    initial begin
        rst          = 1'b0;
        tx_ready     = 1'b0;
        memrw        = 1'b0;
        dmem_addr    = 32'h0;
        dmem_dataout = 32'h0;

        // Reset state
        #1;
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_data",  {24'h0, tx_data},  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Counter after five edges out of reset; empty FIFO status
        repeat (5) @(posedge clk);
        @(negedge clk);
        rd_chk("cycle_n5", A_CYC, 32'd5);
        rd_chk("status_reset", A_ST, 32'h0000_0002);

        // 1. RAM write, direct read, alias and ignored byte-lane bits
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
        rd_chk("ram_lane", 32'h0000_0013, 32'hDEAD_BEEF);
        rd_chk("rsvd_rd", A_RSVD, 32'h0);

        // 2. Fill to full with no consumer, then overflow, then drain
        for (int i = 1; i <= 8; i++) wr(A_TX, i);
        rd_chk("status_full", A_ST, 32'h0000_0801);
        wr(A_TX, 32'h09);
        rd_chk("status_ovf", A_ST, 32'h0000_0805);
        chk("head_after_ovf", {24'h0, tx_data}, 32'h01);
        rd_chk("txdata_rd", A_TX, 32'h0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_data",  {24'h0, tx_data},  i);
            chk("drain_valid", {31'h0, tx_valid}, 32'h1);
            @(negedge clk);
        end
        #1;
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);
        rd_chk("status_drained", A_ST, 32'h0000_0006);
        wr(A_ST, 32'h0000_0004);
        rd_chk("status_w1c", A_ST, 32'h0000_0002);

        // 3. Push while full with a simultaneous pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(A_TX, 32'hA1 + i);
        rd_chk("status_full2", A_ST, 32'h0000_0801);
        tx_ready = 1'b1;
        wr(A_TX, 32'hAA);
        tx_ready = 1'b0;
        rd_chk("status_pushpop", A_ST, 32'h0000_0801);
        chk("head_pushpop", {24'h0, tx_data}, 32'hA2);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain2_data", {24'h0, tx_data}, (i < 7) ? (32'hA2 + i) : 32'hAA);
            @(negedge clk);
        end
        #1;
        chk("drained2_valid", {31'h0, tx_valid}, 32'h0);

        // 4. Backpressure: ready pattern 1,0,0,1 over two queued bytes
        tx_ready = 1'b0;
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        tx_ready = 1'b1;
        #1;
        chk("bp_first", {24'h0, tx_data}, 32'h11);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("bp_stall1", {24'h0, tx_data}, 32'h22);
        chk("bp_stall1_v", {31'h0, tx_valid}, 32'h1);
        @(negedge clk);
        #1;
        chk("bp_stall2", {24'h0, tx_data}, 32'h22);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        chk("bp_release", {24'h0, tx_data}, 32'h22);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("bp_done_valid", {31'h0, tx_valid}, 32'h0);
        rd_chk("bp_status", A_ST, 32'h0000_0002);

        // 5. Counter clear by write, then wrap from all-ones
        wr(A_CYC, 32'h0000_0123);
        rd_chk("cycle_cleared", A_CYC, 32'd0);
        @(negedge clk);
        rd_chk("cycle_after_clr", A_CYC, 32'd1);
        force dut.cycle_r = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_r;
        rd_chk("cycle_max", A_CYC, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_chk("cycle_wrap", A_CYC, 32'h0);

        // 6. Asynchronous reset mid-cycle with three bytes queued
        wr(32'h0000_0020, 32'h1234_5678);
        wr(A_TX, 32'h31);
        wr(A_TX, 32'h32);
        wr(A_TX, 32'h33);
        #2;
        chk("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_valid", {31'h0, tx_valid}, 32'h0);
        chk("async_data",  {24'h0, tx_data},  32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("post_rst_status", A_ST, 32'h0000_0002);
        rd_chk("post_rst_cycle", A_CYC, 32'h0);
        rd_chk("post_rst_ram", 32'h0000_0020, 32'h1234_5678);
        rd_chk("post_rst_ram2", 32'h0000_0010, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
